// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI slave shift register and the RAM back end.
// master = SPI slave side (issues commands), slave = RAM side (answers them).
interface spi_ram_burst_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W+1:0] din;
   logic              rx_valid;
   logic [DATA_W-1:0] dout;
   logic              tx_valid;
   logic              addr_err;

   modport master (
      output din,
      output rx_valid,
      input  dout,
      input  tx_valid,
      input  addr_err
   );

   modport slave (
      input  din,
      input  rx_valid,
      output dout,
      output tx_valid,
      output addr_err
   );
endinterface

// File: rtl/spi_ram_burst.sv
// SPI-slave RAM back end: decodes opcode+payload command words into a MEM_DEPTH x DATA_W RAM.
// Optional burst addressing (post-increment of wr/rd address) when SPI_RAM_AUTOINC_EN is defined.
module spi_ram_burst #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MEM_DEPTH = 256
) (
   input logic            clk,
   input logic            rst_n,
   spi_ram_burst_if.slave bus
);

   typedef enum logic [1:0] {
      OpSetWr  = 2'b00,
      OpWrData = 2'b01,
      OpSetRd  = 2'b10,
      OpRdData = 2'b11
   } op_e;

   localparam int unsigned     IdxW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   // One extra bit so MEM_DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(MEM_DEPTH);

   if (ADDR_W > DATA_W || MEM_DEPTH == 0 || 64'(MEM_DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_params
      $error("spi_ram_burst: illegal DATA_W/ADDR_W/MEM_DEPTH combination");
   end

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   op_e               op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] payload;
   logic              wr_in_range;
   logic              rd_in_range;

   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              tx_valid_q, tx_valid_d;
   logic              addr_err_q, addr_err_d;
   logic              mem_we;

   assign op          = op_e'(bus.din[DATA_W+1:DATA_W]);
   assign payload     = bus.din[DATA_W-1:0];
   assign cmd_addr    = bus.din[ADDR_W-1:0];
   assign wr_in_range = {1'b0, wr_addr_q} < DepthL;
   assign rd_in_range = {1'b0, rd_addr_q} < DepthL;

`ifdef SPI_RAM_AUTOINC_EN
   // Post-increment that wraps to 0 at the last word and from any out-of-range address.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] inc;
      inc = {1'b0, a} + (ADDR_W + 1)'(1);
      return (inc < DepthL) ? inc[ADDR_W-1:0] : '0;
   endfunction
`endif

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      dout_d     = dout_q;
      tx_valid_d = 1'b0;
      addr_err_d = 1'b0;
      mem_we     = 1'b0;
      if (bus.rx_valid) begin
         unique case (op)
            OpSetWr: wr_addr_d = cmd_addr;
            OpWrData: begin
               mem_we     = wr_in_range;
               addr_err_d = !wr_in_range;
`ifdef SPI_RAM_AUTOINC_EN
               wr_addr_d  = next_addr(wr_addr_q);
`endif
            end
            OpSetRd: rd_addr_d = cmd_addr;
            OpRdData: begin
               tx_valid_d = 1'b1;
               addr_err_d = !rd_in_range;
               dout_d     = rd_in_range ? mem[rd_addr_q[IdxW-1:0]] : '0;
`ifdef SPI_RAM_AUTOINC_EN
               rd_addr_d  = next_addr(rd_addr_q);
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Memory is not reset; a command in a reset cycle must not write.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[wr_addr_q[IdxW-1:0]] <= payload;
      end
   end

   assign bus.dout     = dout_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: a full-depth and a 200-word instance driven in lockstep,
// checked every cycle against a command-level model plus literal expectations.
module tb_spi_ram_burst;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   spi_ram_burst_if #(.DATA_W(8)) if_a ();
   spi_ram_burst_if #(.DATA_W(8)) if_b ();

   spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a.slave)
   );

   spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b.slave)
   );

   // Command-level model, index 0 = depth 256, index 1 = depth 200.
   logic [7:0] m_mem [2][256];
   int         m_wr [2];
   int         m_rd [2];
   logic [7:0] m_dout [2];
   logic       m_tx [2];
   logic       m_err [2];

   function automatic int bump(input int a, input int depth);
`ifdef SPI_RAM_AUTOINC_EN
      return (a + 1 < depth) ? a + 1 : 0;
`else
      return a + 0 * depth;
`endif
   endfunction

   task automatic model_step(input int k, input bit r, input bit v, input logic [9:0] d);
      int depth;
      depth = (k == 0) ? 256 : 200;
      if (!r) begin
         m_wr[k] = 0; m_rd[k] = 0; m_dout[k] = 8'h00; m_tx[k] = 1'b0; m_err[k] = 1'b0;
         return;
      end
      m_tx[k]  = 1'b0;
      m_err[k] = 1'b0;
      if (v) begin
         case (d[9:8])
            2'b00: m_wr[k] = int'(d[7:0]);
            2'b01: begin
               if (m_wr[k] < depth) m_mem[k][m_wr[k]] = d[7:0];
               else m_err[k] = 1'b1;
               m_wr[k] = bump(m_wr[k], depth);
            end
            2'b10: m_rd[k] = int'(d[7:0]);
            default: begin
               m_tx[k] = 1'b1;
               if (m_rd[k] < depth) m_dout[k] = m_mem[k][m_rd[k]];
               else begin
                  m_dout[k] = 8'h00;
                  m_err[k]  = 1'b1;
               end
               m_rd[k] = bump(m_rd[k], depth);
            end
         endcase
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle with the given inputs; outputs settle by #1 after the edge.
   task automatic cyc(input bit r, input bit v, input logic [9:0] d);
      rst_n        = r;
      if_a.rx_valid = v;
      if_b.rx_valid = v;
      if_a.din     = d;
      if_b.din     = d;
      @(posedge clk);
      model_step(0, r, v, d);
      model_step(1, r, v, d);
      chk_en = 1'b1;
      #1;
   endtask

   task automatic cmd(input logic [1:0] op, input logic [7:0] p);
      cyc(1'b1, 1'b1, {op, p});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 10'h000);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("a_dout", if_a.dout, m_dout[0]);
         chk("a_tx_valid", {7'b0, if_a.tx_valid}, {7'b0, m_tx[0]});
         chk("a_addr_err", {7'b0, if_a.addr_err}, {7'b0, m_err[0]});
         chk("b_dout", if_b.dout, m_dout[1]);
         chk("b_tx_valid", {7'b0, if_b.tx_valid}, {7'b0, m_tx[1]});
         chk("b_addr_err", {7'b0, if_b.addr_err}, {7'b0, m_err[1]});
      end
   end

   logic [7:0] exp4 [3];

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 256; i++) m_mem[k][i] = 8'h00;
      end
      if_a.rx_valid = 1'b0;
      if_b.rx_valid = 1'b0;
      if_a.din = '0;
      if_b.din = '0;

      // Reset and idle
      cyc(1'b0, 1'b0, 10'h000);
      cyc(1'b0, 1'b0, 10'h000);
      chk("rst_dout", if_a.dout, 8'h00);
      chk("rst_tx", {7'b0, if_a.tx_valid}, 8'h00);
      chk("rst_err", {7'b0, if_b.addr_err}, 8'h00);
      idle(5);
      chk("idle_dout", if_b.dout, 8'h00);

      // Basic write/read
      cmd(2'b00, 8'h12);
      cmd(2'b01, 8'hA5);
      cmd(2'b10, 8'h12);
      cmd(2'b11, 8'h00);
      chk("t2_dout", if_a.dout, 8'hA5);
      chk("t2_tx", {7'b0, if_a.tx_valid}, 8'h01);
      chk("t2_b_dout", if_b.dout, 8'hA5);
      idle(1);
      chk("t2_tx_drop", {7'b0, if_a.tx_valid}, 8'h00);
      idle(2);
      chk("t2_hold", if_a.dout, 8'hA5);

      // Out-of-range on the 200-word instance
      cmd(2'b00, 8'hC8);
      cmd(2'b01, 8'h33);
      chk("t3_wr_err_b", {7'b0, if_b.addr_err}, 8'h01);
      chk("t3_wr_err_a", {7'b0, if_a.addr_err}, 8'h00);
      cmd(2'b10, 8'hC8);
      cmd(2'b11, 8'h00);
      chk("t3_b_dout", if_b.dout, 8'h00);
      chk("t3_b_tx", {7'b0, if_b.tx_valid}, 8'h01);
      chk("t3_b_err", {7'b0, if_b.addr_err}, 8'h01);
      chk("t3_a_dout", if_a.dout, 8'h33);

      // Burst across the top of the address space
`ifdef SPI_RAM_AUTOINC_EN
      exp4[0] = 8'h01; exp4[1] = 8'h02; exp4[2] = 8'h03;
`else
      exp4[0] = 8'h03; exp4[1] = 8'h03; exp4[2] = 8'h03;
`endif
      cmd(2'b00, 8'hFE);
      cmd(2'b01, 8'h01);
      cmd(2'b01, 8'h02);
      cmd(2'b01, 8'h03);
      cmd(2'b10, 8'hFE);
      for (int i = 0; i < 3; i++) begin
         cmd(2'b11, 8'h00);
         chk("t4_dout", if_a.dout, exp4[i]);
         chk("t4_tx", {7'b0, if_a.tx_valid}, 8'h01);
      end
      idle(1);

      // Read immediately after write to the same address
      cmd(2'b00, 8'h20);
      cmd(2'b10, 8'h20);
      cmd(2'b01, 8'h3C);
      cmd(2'b11, 8'h00);
      chk("raw_dout", if_a.dout, 8'h3C);

      // Reset in the same cycle as RD_DATA
      cmd(2'b00, 8'h00);
      cmd(2'b01, 8'h77);
      cmd(2'b00, 8'h40);
      cmd(2'b01, 8'h5A);
      cmd(2'b10, 8'h40);
      cyc(1'b0, 1'b1, {2'b11, 8'h00});
      chk("t5_rst_tx", {7'b0, if_a.tx_valid}, 8'h00);
      chk("t5_rst_dout", if_a.dout, 8'h00);
      cmd(2'b11, 8'h00);
      chk("t5_rd_addr0", if_a.dout, 8'h77);
      cmd(2'b10, 8'h40);
      cmd(2'b11, 8'h00);
      chk("t5_retained_a", if_a.dout, 8'h5A);
      chk("t5_retained_b", if_b.dout, 8'h5A);
      idle(2);

      @(negedge clk);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
